// File: rtl/dm_loader.sv
// dm_loader: streams bytes into data memory, pulses the processor start, then streams results back out
// Ports:
//   clk_i, rst_ni                              clock, asynchronous active-low reset
//   start_i                                    begin one load/run/dump sequence (taken only when idle)
//   in_valid_i, in_data_i, in_ready_o          load byte stream
//   mem_adr_o, dat_in_o, write_en_o, read_en_o data-memory master port
//   dat_out_i                                  data-memory read data (combinational from mem_adr_o)
//   req_o, ack_i                               processor start/done handshake
//   out_valid_o, out_data_o, out_ready_i       result byte stream
//   done_o, timeout_err_o                      end-of-sequence pulse, sticky abort flag
module dm_loader #(
  parameter logic [7:0]  LOAD_BASE = 8'd0,
  parameter logic [8:0]  LOAD_LEN  = 9'd64,
  parameter logic [7:0]  RES_BASE  = 8'd128,
  parameter logic [8:0]  RES_LEN   = 9'd16,
  parameter logic [15:0] TIMEOUT   = 16'd4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic [7:0] mem_adr_o,
  output logic [7:0] dat_in_o,
  output logic       write_en_o,
  output logic       read_en_o,
  input  logic [7:0] dat_out_i,
  output logic       req_o,
  input  logic       ack_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic       done_o,
  output logic       timeout_err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DUMP, DONE} state_e;
  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] run_q, run_d;
  logic        tmo_q, tmo_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    in_ready_o  = 1'b0;
    write_en_o  = 1'b0;
    read_en_o   = 1'b0;
    req_o       = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    mem_adr_o   = '0;
    dat_in_o    = '0;
    out_data_o  = '0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = (LOAD_LEN == 9'd0) ? START : LOAD;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
      LOAD: begin
        in_ready_o = 1'b1;
        write_en_o = in_valid_i;
        mem_adr_o  = LOAD_BASE + cnt_q[7:0];
        dat_in_o   = in_data_i;
        if (in_valid_i) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = (cnt_q == LOAD_LEN - 9'd1) ? START : LOAD;
        end
      end
      START: begin
        req_o   = 1'b1;
        run_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        run_d = run_q + 16'd1;
        // ack on the final allowed cycle still counts as success
        if (ack_i)
          state_d = (RES_LEN == 9'd0) ? DONE : DUMP;
        else if (run_q == TIMEOUT - 16'd1) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DUMP: begin
        read_en_o   = 1'b1;
        out_valid_o = 1'b1;
        mem_adr_o   = RES_BASE + cnt_q[7:0];
        out_data_o  = dat_out_i;
        if (out_ready_i) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = (cnt_q == RES_LEN - 9'd1) ? DONE : DUMP;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign timeout_err_o = tmo_q;
endmodule

// File: tb/tb_dm_loader.sv
// tb_dm_loader: randomized self-checking bench for dm_loader against a memory-image reference model
module tb_dm_loader;
  localparam logic [7:0]  LB = 8'd254;
  localparam logic [8:0]  LL = 9'd4;
  localparam logic [7:0]  RB = 8'd128;
  localparam logic [8:0]  RL = 9'd3;
  localparam logic [15:0] TO = 16'd8;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, ack = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, write_en, read_en, req, out_valid, done, timeout_err;
  logic [7:0] mem_adr, dat_in, dat_out, out_data;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ld [$];
  logic [15:0] wq [$];
  logic [7:0] oq [$];
  int cyc = 0, n_req = 0, n_done = 0, n_ov = 0, n_both = 0, req_cyc = 0, done_cyc = 0, last_in_cyc = 0;
  int pass = 0, total = 0;
  dm_loader #(.LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .mem_adr_o(mem_adr), .dat_in_o(dat_in), .write_en_o(write_en), .read_en_o(read_en),
    .dat_out_i(dat_out), .req_o(req), .ack_i(ack),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .done_o(done), .timeout_err_o(timeout_err)
  );
  always #5 clk = ~clk;
  assign dat_out = mem[mem_adr];
  always @(posedge clk) begin
    cyc++;
    if (write_en) begin
      mem[mem_adr] = dat_in;
      wq.push_back({mem_adr, dat_in});
    end
    if (in_valid && in_ready) last_in_cyc = cyc;
    if (req) begin n_req++; req_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (out_valid) n_ov++;
    if (write_en && read_en) n_both++;
    if (out_valid && out_ready) oq.push_back(out_data);
  end

  task automatic do_load_ack(input int ack_dly, input bit ack_never, input bit poke);
    int sent = 0, g = 0;
    ld.delete(); wq.delete(); oq.delete();
    n_req = 0; n_done = 0; n_ov = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (sent < int'(LL) && g < 100) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      #1;
      if (in_valid && in_ready) begin ld.push_back(in_data); sent++; end
      @(negedge clk); g++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < ld.size(); i++) ref_mem[8'((int'(LB) + i) % 256)] = ld[i];
    g = 0;
    while (!req && g < 20) begin @(negedge clk); g++; end
    for (int i = 1; i <= ack_dly; i++) begin @(negedge clk); start = poke && i == 1; end
    start = 1'b0;
    if (!ack_never) begin ack = 1'b1; @(negedge clk); ack = 1'b0; end
  endtask

  task automatic do_dump(input bit rnd);
    int g = 0, nd = n_done;
    while (n_done == nd && g < 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      g++;
    end
    out_ready = 1'b0;
    if (n_done == nd) begin total++; $display("FAIL dump_bound: no done within 200 cycles"); end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({in_ready, write_en, read_en, req, out_valid, done, timeout_err, mem_adr, dat_in, out_data} !== 31'd0)
      $display("FAIL reset_outputs: got %b want 0", {in_ready, write_en, read_en, req, out_valid, done, timeout_err, mem_adr, dat_in, out_data});
    else pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, write_en, req, out_valid, done, timeout_err} !== 6'd0) $display("FAIL idle_outputs: got %b want 0", {in_ready, write_en, req, out_valid, done, timeout_err});
    else pass++;
  endtask

  task automatic test_load_run_dump;
    do_load_ack($urandom_range(1, 7), 1'b0, 1'b0);
    do_dump(1'b1);
    total++;
    if (wq.size() != int'(LL)) $display("FAIL write_count: got %0d want %0d", wq.size(), LL); else pass++;
    for (int i = 0; i < wq.size() && i < ld.size(); i++) begin
      total++;
      if (wq[i] !== {8'((int'(LB) + i) % 256), ld[i]}) $display("FAIL write_%0d: got %h want %h", i, wq[i], {8'((int'(LB) + i) % 256), ld[i]});
      else pass++;
    end
    total++;
    if (n_req != 1 || req_cyc != last_in_cyc + 1) $display("FAIL req_pulse: got n=%0d at %0d want n=1 at %0d", n_req, req_cyc, last_in_cyc + 1);
    else pass++;
    total++;
    if (oq.size() != int'(RL)) $display("FAIL out_count: got %0d want %0d", oq.size(), RL); else pass++;
    for (int i = 0; i < oq.size() && i < int'(RL); i++) begin
      total++;
      if (oq[i] !== ref_mem[8'((int'(RB) + i) % 256)]) $display("FAIL out_%0d: got %h want %h", i, oq[i], ref_mem[8'((int'(RB) + i) % 256)]);
      else pass++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (n_done != 1 || timeout_err !== 1'b0 || in_ready !== 1'b0) $display("FAIL done_once: got n=%0d tmo=%b rdy=%b want 1 0 0", n_done, timeout_err, in_ready);
    else pass++;
  endtask

  task automatic test_stall;
    int g = 0;
    do_load_ack($urandom_range(1, 7), 1'b0, 1'b0);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || mem_adr !== 8'(RB + 8'd1) || out_data !== ref_mem[8'(RB + 8'd1)])
        $display("FAIL stall_%0d: got v=%b a=%h d=%h want 1 %h %h", i, out_valid, mem_adr, out_data, 8'(RB + 8'd1), ref_mem[8'(RB + 8'd1)]);
      else pass++;
      @(negedge clk);
    end
    do_dump(1'b0);
    total++;
    if (oq.size() != int'(RL)) $display("FAIL stall_count: got %0d want %0d", oq.size(), RL); else pass++;
    for (int i = 0; i < oq.size() && i < int'(RL); i++) begin
      total++;
      if (oq[i] !== ref_mem[8'((int'(RB) + i) % 256)]) $display("FAIL stall_out_%0d: got %h want %h", i, oq[i], ref_mem[8'((int'(RB) + i) % 256)]);
      else pass++;
    end
    g = g + 0;
  endtask

  task automatic test_timeout;
    int g = 0;
    do_load_ack(0, 1'b1, 1'b0);
    while (n_done == 0 && g < 40) begin @(negedge clk); g++; end
    @(negedge clk);
    total++;
    if (n_done != 1 || done_cyc - req_cyc != 9) $display("FAIL tmo_done: got n=%0d after %0d want 1 after 9", n_done, done_cyc - req_cyc);
    else pass++;
    total++;
    if (timeout_err !== 1'b1 || n_ov != 0) $display("FAIL tmo_flag: got tmo=%b ov=%0d want 1 0", timeout_err, n_ov); else pass++;
    repeat (3) @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", timeout_err); else pass++;
    start = 1'b1; @(negedge clk); start = 1'b0;
    total++;
    if (timeout_err !== 1'b0 || in_ready !== 1'b1) $display("FAIL tmo_clear: got tmo=%b rdy=%b want 0 1", timeout_err, in_ready); else pass++;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_ack_tie;
    do_load_ack(int'(TO), 1'b0, 1'b0);
    do_dump(1'b1);
    total++;
    if (timeout_err !== 1'b0 || oq.size() != int'(RL)) $display("FAIL ack_tie: got tmo=%b n=%0d want 0 %0d", timeout_err, oq.size(), RL);
    else pass++;
  endtask

  task automatic test_reset_mid;
    do_load_ack(3, 1'b0, 1'b0);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, write_en, read_en, req, out_valid, done, timeout_err, mem_adr, dat_in, out_data} !== 31'd0)
      $display("FAIL mid_reset: got %b want 0", {in_ready, write_en, read_en, req, out_valid, done, timeout_err, mem_adr, dat_in, out_data});
    else pass++;
    repeat (2) @(negedge clk);
    wq.delete(); n_req = 0; n_done = 0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (n_req != 0 || wq.size() != 0 || n_done != 0) $display("FAIL abandon: got req=%0d wr=%0d done=%0d want 0", n_req, wq.size(), n_done);
    else pass++;
    do_load_ack(4, 1'b0, 1'b1);
    do_dump(1'b1);
    total++;
    if (oq.size() != int'(RL) || wq.size() != int'(LL)) $display("FAIL restart: got out=%0d wr=%0d want %0d %0d", oq.size(), wq.size(), RL, LL);
    else pass++;
    repeat (4) @(negedge clk);
    total++;
    if (n_req != 1 || wq.size() != int'(LL) || in_ready !== 1'b0) $display("FAIL start_ignored: got req=%0d wr=%0d rdy=%b want 1 %0d 0", n_req, wq.size(), in_ready, LL);
    else pass++;
  endtask

  task automatic test_exclusive;
    total++;
    if (n_both != 0) $display("FAIL rw_exclusive: got %0d overlapping cycles want 0", n_both); else pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_run_dump();
    test_stall();
    test_timeout();
    test_ack_tie();
    test_reset_mid();
    test_load_run_dump();
    test_exclusive();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/dm_loader.md
DM_LOADER -- requirements
Module: dm_loader

Interface
REQ-001 Parameter LOAD_BASE, default 8'd0: first data-memory address written during load.
REQ-002 Parameter LOAD_LEN, default 9'd64: bytes loaded per run (0..256).
REQ-003 Parameter RES_BASE, default 8'd128: first data-memory address read back during dump.
REQ-004 Parameter RES_LEN, default 9'd16: bytes dumped per run (0..256).
REQ-005 Parameter TIMEOUT, default 16'd4096: maximum RUN cycles before abort.
REQ-006 clk  in  1  single clock; all state updates on posedge clk.
REQ-007 reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-008 start  in  1  begin one load/run/dump sequence; honoured only in IDLE.
REQ-009 in_valid  in  1 / in_data  in  8 / in_ready  out  1  load byte stream; beat = in_valid&&in_ready.
REQ-010 MemAdr  out  8 / DatIn  out  8 / WriteEn  out  1 / ReadEn  out  1  data-memory master port.
REQ-011 DatOut  in  8  data-memory read data, combinational from MemAdr.
REQ-012 req  out  1 / ack  in  1  processor start/done handshake.
REQ-013 out_valid  out  1 / out_data  out  8 / out_ready  in  1  result byte stream; beat = out_valid&&out_ready.
REQ-014 done  out  1  one-cycle pulse at end of sequence; timeout_err  out  1  sticky abort flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, RUN, DUMP, DONE, with a 9-bit beat counter and 16-bit run counter.
REQ-016 IDLE: start==1 -> LOAD (LOAD_LEN>0) or START (LOAD_LEN==0); beat counter and timeout_err cleared.
REQ-017 LOAD: in_ready=1; WriteEn=in_valid; MemAdr=LOAD_BASE+cnt (mod 256); DatIn=in_data; cnt++ per beat.
REQ-018 LOAD: beat with cnt==LOAD_LEN-1 -> START next cycle; no further in_ready.
REQ-019 START: req=1 for exactly one cycle; ack ignored; run counter cleared -> RUN.
REQ-020 RUN: req=0; ack==1 -> DUMP (RES_LEN>0) or DONE (RES_LEN==0); run counter +1 per cycle.
REQ-021 RUN: run counter reaching TIMEOUT-1 with ack==0 -> timeout_err=1, -> DONE (DUMP skipped); ack same cycle wins.
REQ-022 DUMP: ReadEn=1; MemAdr=RES_BASE+cnt (mod 256); out_valid=1; out_data=DatOut; cnt++ per beat.
REQ-023 DUMP: out_valid held, MemAdr stable while out_ready==0; beat with cnt==RES_LEN-1 -> DONE.
REQ-024 DONE: done=1 one cycle -> IDLE; timeout_err held until next accepted start.
REQ-025 Outside LOAD: in_ready=0, WriteEn=0; outside DUMP: ReadEn=0, out_valid=0; MemAdr=0, DatIn=0 when neither.
REQ-026 start asserted outside IDLE SHALL be ignored (not queued).
REQ-027 WriteEn and ReadEn SHALL never be 1 in the same cycle.

Reset
REQ-028 reset==0 SHALL immediately force IDLE, counters 0, and in_ready, WriteEn, ReadEn, req, out_valid, done, timeout_err, MemAdr, DatIn, out_data all 0.
REQ-029 Reset mid-LOAD/RUN/DUMP SHALL abandon the sequence; no further memory writes or req until a new start.

Verification
REQ-030 LOAD_LEN=4, bytes 11,22,33,44 with gaps -> writes at 0..3 only on beats; req one cycle after 4th beat.
REQ-031 ack high 10 cycles after req, RES_LEN=2, mem[128]=AA,[129]=BB -> out bytes AA,BB; done pulses once.
REQ-032 out_ready low 5 cycles mid-dump -> out_data/MemAdr stable, no byte lost or duplicated.
REQ-033 TIMEOUT=8, ack never -> timeout_err=1 after 8 RUN cycles, no out_valid, done pulse; cleared by next start.
REQ-034 LOAD_BASE=254, LOAD_LEN=4 -> writes at 254,255,0,1.
REQ-035 reset low during DUMP, then start -> full new sequence from LOAD; start during RUN ignored.
